// File: rtl/pipeline_join_blocking.sv
// rtl/pipeline_join_blocking.sv - lockstep join of N ready/valid streams into one via a 2-entry skid buffer
// Optional skew counter output enabled by PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN.
module pipeline_join_blocking #(
  parameter int WORD_WIDTH = 8,
  parameter int INPUT_COUNT = 2,
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
  parameter int SKEW_COUNT_WIDTH = 16,
`endif
  localparam int TOTAL_WIDTH = WORD_WIDTH * INPUT_COUNT
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic [INPUT_COUNT-1:0]      input_valid,
  output logic [INPUT_COUNT-1:0]      input_ready,
  input  logic [TOTAL_WIDTH-1:0]      input_data,
  output logic                        output_valid,
  input  logic                        output_ready,
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
  output logic [SKEW_COUNT_WIDTH-1:0] skew_cycles,
`endif
  output logic [TOTAL_WIDTH-1:0]      output_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  buf_state_t             state, state_next;
  logic [TOTAL_WIDTH-1:0] main_q, main_next;
  logic [TOTAL_WIDTH-1:0] skid_q, skid_next;

  logic all_valid;
  logic buf_ready;
  logic load;
  logic unload;

  // Readiness comes only from registered state so output_ready never reaches the inputs.
  assign all_valid   = &input_valid;
  assign buf_ready   = (state != FULL);
  assign load        = all_valid & buf_ready & clear_n;
  assign input_ready = {INPUT_COUNT{load}};

  assign output_valid = (state != EMPTY) & clear_n;
  assign output_data  = main_q;
  assign unload       = output_valid & output_ready;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state)
      EMPTY: begin
        if (load) begin
          state_next = BUSY;
          main_next  = input_data;
        end
      end
      BUSY: begin
        if (load && unload) begin
          main_next = input_data;
        end else if (unload) begin
          state_next = EMPTY;
        end else if (load) begin
          state_next = FULL;
          skid_next  = input_data;
        end
      end
      FULL: begin
        // load cannot occur here: buf_ready is low while FULL.
        if (unload) begin
          state_next = BUSY;
          main_next  = skid_q;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
  logic partial_valid;
  assign partial_valid = (|input_valid) & ~all_valid;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      skew_cycles <= '0;
    end else if (partial_valid && (skew_cycles != {SKEW_COUNT_WIDTH{1'b1}})) begin
      skew_cycles <= skew_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_join_blocking.sv
// tb/tb_pipeline_join_blocking.sv - randomized bench for pipeline_join_blocking against a FIFO reference model
module tb_pipeline_join_blocking;
  localparam int W = 8;
  localparam int N = 2;
  localparam int T = W * N;

  logic         clock = 1'b0;
  logic         clear_n;
  logic [N-1:0] input_valid;
  logic [N-1:0] input_ready;
  logic [T-1:0] input_data;
  logic         output_valid;
  logic         output_ready;
  logic [T-1:0] output_data;

  int compared = 0;
  int mismatched = 0;
  int joins = 0;
  logic [T-1:0] model_q[$];

`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
  localparam int SW = 4;
  logic [SW-1:0] skew_cycles;
  int skew_model = 0;

  pipeline_join_blocking #(.WORD_WIDTH(W), .INPUT_COUNT(N), .SKEW_COUNT_WIDTH(SW)) dut (
    .clock(clock), .clear_n(clear_n), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .output_valid(output_valid), .output_ready(output_ready),
    .skew_cycles(skew_cycles), .output_data(output_data));
`else
  pipeline_join_blocking #(.WORD_WIDTH(W), .INPUT_COUNT(N)) dut (
    .clock(clock), .clear_n(clear_n), .input_valid(input_valid), .input_ready(input_ready),
    .input_data(input_data), .output_valid(output_valid), .output_ready(output_ready),
    .output_data(output_data));
`endif

  always #5 clock = ~clock;

  // One clock cycle: check mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    logic         exp_join;
    logic         exp_valid;
    logic         exp_unload;
    logic [T-1:0] word;
    @(negedge clock);
    exp_join  = clear_n && (&input_valid) && (model_q.size() < 2);
    exp_valid = clear_n && (model_q.size() > 0);
    compared++;
    if (input_ready !== {N{exp_join}}) begin
      mismatched++;
      $display("FAIL input_ready: got %b expected %b at %0t", input_ready, {N{exp_join}}, $time);
    end
    compared++;
    if (output_valid !== exp_valid) begin
      mismatched++;
      $display("FAIL output_valid: got %b expected %b at %0t", output_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      compared++;
      if (output_data !== model_q[0]) begin
        mismatched++;
        $display("FAIL output_data: got %h expected %h at %0t", output_data, model_q[0], $time);
      end
    end
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
    compared++;
    if (skew_cycles !== SW'(skew_model)) begin
      mismatched++;
      $display("FAIL skew_cycles: got %0d expected %0d at %0t", skew_cycles, skew_model, $time);
    end
`endif
    exp_unload = exp_valid && output_ready;
    word = input_data;
    @(posedge clock);
    if (!clear_n) begin
      model_q.delete();
    end else begin
      if (exp_unload) void'(model_q.pop_front());
      if (exp_join) begin
        model_q.push_back(word);
        joins++;
      end
    end
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
    if (!clear_n) skew_model = 0;
    else if ((input_valid != '0) && (input_valid != '1) && skew_model < (1 << SW) - 1) skew_model++;
`endif
    #1;
  endtask

  task automatic drain(input int cycles);
    input_valid  = '0;
    output_ready = 1'b1;
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic test_reset();
    clear_n      = 1'b0;
    input_valid  = '1;
    input_data   = 16'h1234;
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    model_q.delete();
    for (int i = 0; i < 3; i++) step();
    compared++;
    if (output_data !== '0) begin
      mismatched++;
      $display("FAIL reset_output_data: got %h expected 0", output_data);
    end
    clear_n = 1'b1;
    step();
    compared++;
    if (output_valid !== 1'b1 || output_data !== 16'h1234) begin
      mismatched++;
      $display("FAIL reset_first_join: got valid %b data %h expected 1 1234", output_valid, output_data);
    end
    drain(3);
  endtask

  task automatic test_skew();
    clear_n = 1'b0;
    step();
    clear_n      = 1'b1;
    output_ready = 1'b1;
    input_valid  = 2'b01;
    input_data   = {8'($urandom), 8'hA5};
    for (int i = 0; i < 4; i++) step();
    input_valid = 2'b11;
    input_data  = 16'h3CA5;
    step();
    input_valid = 2'b00;
    compared++;
    if (output_valid !== 1'b1 || output_data !== 16'h3CA5) begin
      mismatched++;
      $display("FAIL skew_join: got valid %b data %h expected 1 3ca5", output_valid, output_data);
    end
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
    compared++;
    if (skew_cycles !== 4'd4) begin
      mismatched++;
      $display("FAIL skew_count: got %0d expected 4", skew_cycles);
    end
`endif
    drain(2);
  endtask

  task automatic test_streaming();
    int start;
    start = joins;
    output_ready = 1'b1;
    input_valid  = '1;
    for (int i = 0; i < 10; i++) begin
      input_data = {8'(i), 8'(i)};
      step();
    end
    compared++;
    if (joins - start != 10) begin
      mismatched++;
      $display("FAIL stream_joins: got %0d expected 10", joins - start);
    end
    drain(3);
  endtask

  task automatic test_backpressure();
    int start;
    start = joins;
    output_ready = 1'b0;
    input_valid  = '1;
    for (int i = 0; i < 5; i++) begin
      input_data = 16'($urandom);
      step();
    end
    compared++;
    if (joins - start != 2) begin
      mismatched++;
      $display("FAIL backpressure_accepted: got %0d expected 2", joins - start);
    end
    output_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      input_data = 16'($urandom);
      step();
    end
    drain(4);
    compared++;
    if (output_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_drained: got valid %b expected 0", output_valid);
    end
  endtask

  task automatic test_mid_reset();
    output_ready = 1'b0;
    input_valid  = '1;
    for (int i = 0; i < 3; i++) begin
      input_data = 16'($urandom);
      step();
    end
    clear_n = 1'b0;
    step();
    clear_n     = 1'b1;
    input_valid = '0;
    compared++;
    if (output_valid !== 1'b0 || output_data !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_flush: got valid %b data %h expected 0 0", output_valid, output_data);
    end
    output_ready = 1'b1;
    input_valid  = '1;
    for (int i = 0; i < 4; i++) begin
      input_data = 16'($urandom);
      step();
    end
    drain(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clear_n      = ($urandom_range(0, 99) != 0);
      input_valid  = ($urandom_range(0, 2) != 0) ? 2'b11 : N'($urandom);
      output_ready = ($urandom_range(0, 3) != 0);
      input_data   = 16'($urandom);
      step();
    end
    clear_n = 1'b1;
    drain(4);
  endtask

`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
  task automatic test_saturation();
    clear_n = 1'b0;
    step();
    clear_n     = 1'b1;
    input_valid = 2'b10;
    for (int i = 0; i < 20; i++) step();
    compared++;
    if (skew_cycles !== 4'hF) begin
      mismatched++;
      $display("FAIL skew_saturation: got %0d expected 15", skew_cycles);
    end
    drain(2);
  endtask
`endif

  initial begin
    test_reset();
    test_skew();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_random();
`ifdef PIPELINE_JOIN_BLOCKING_SKEW_COUNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
